register_file_sb: RTL and testbench
===================================

# register_file_sb

Parametrised register file with a built-in scoreboard for the pipelined MIPS datapath. It supersedes the fixed 8×16 register file in the decode stage. It adds configurable width and depth, an optional hardwired-zero register, optional write-to-read bypass, and per-register busy tracking. Decode uses the busy tracking to detect RAW and WAW hazards and to stall issue until writeback clears them.

## Interface
- WIDTH, 16, data width of each register
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, when 1 register 0 always reads 0, ignores writes and is never marked busy
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports and counts as clearing busy for hazard checks
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- write  input  1  writeback strobe
- wreg  input  ADDR_W  writeback register address
- wd  input  WIDTH  writeback data
- rreg1, rreg2  input  ADDR_W  source register addresses
- rd1, rd2  output  WIDTH  source data (combinational)
- issue  input  1  decode requests issue of an instruction that reads rreg1/rreg2 and will write ireg
- ireg  input  ADDR_W  destination register claimed by the issuing instruction
- stall  output  1  issue refused this cycle (combinational)
- busy1, busy2  output  1  effective busy status of rreg1/rreg2 (combinational)
- pend_cnt  output  ADDR_W+1  number of registers currently marked busy (registered)

## Operation
- State: DEPTH×WIDTH data array, DEPTH-bit busy vector, pend_cnt counter.
- Write: when write=1, at the rising edge regs[wreg] <= wd. The write is suppressed if ZERO_REG=1 and wreg=0.
- Read: rdN = regs[rregN].
  - Override 1: rdN = 0 if ZERO_REG=1 and rregN=0.
  - Override 2: otherwise rdN = wd if BYPASS=1, write=1 and wreg=rregN.
- Effective busy: busyN = busy[rregN].
  - Forced 0 if ZERO_REG=1 and rregN=0.
  - Forced 0 if BYPASS=1, write=1 and wreg=rregN.
- WAW check: wbusy = busy[ireg], with the same two overrides applied to ireg.
- stall = issue & (busy1 | busy2 | wbusy).
- Accept: acc = issue & ~stall.
  - On acc, busy[ireg] <= 1 at the edge, unless ZERO_REG=1 and ireg=0.
- Clear: a write sets busy[wreg] <= 0 at the edge. Exception: if acc is also claiming the same register in that cycle, the claim wins and busy stays 1 for the new producer.
- Write to a non-busy register is legal. Data updates and busy stays 0.
- pend_cnt follows popcount of busy.
  - Updated incrementally each edge: +1 for an effective set of a previously clear bit, −1 for an effective clear of a set bit.
  - Net 0 when both apply to different registers.
  - Never exceeds DEPTH (or DEPTH−1 with ZERO_REG=1).
- Reset (rst=0, asynchronous): all registers 0, busy all 0, pend_cnt 0.
  - Outputs during reset: rd1/rd2 follow reads of the zeroed array, except that the bypass still forwards wd when write=1. busyN=0, stall=0.
  - Writes and issues presented while rst=0 have no effect.
- Deassertion of rst is synchronised externally; the first edge after release may write or issue.

## Timing
- Read and hazard outputs are combinational from addresses, write, wreg, wd and current state, with zero latency.
- Write data is visible on a same-address read:
  - same cycle when BYPASS=1;
  - first cycle after the edge when BYPASS=0.
- Busy set is visible the cycle after the accepting edge. Busy clear is visible the cycle after the write edge, or the same cycle when BYPASS=1.
- pend_cnt is registered and reflects the busy vector with no extra lag.
- No multi-cycle operations; every accepted request completes in one edge.

## Test plan
- Reset then basic R/W (defaults):
  - rst=0, then release. All reads return 0 and pend_cnt=0.
  - Write r3=16'hBEEF. The next cycle rreg1=3 gives rd1=16'hBEEF.
- Bypass:
  - BYPASS=1: write=1, wreg=5, wd=16'h1234, rreg2=5 in the same cycle gives rd2=16'h1234 and busy2=0 before the edge.
  - BYPASS=0: the same stimulus gives the old value (0).
- RAW stall:
  - Issue ireg=2, which is accepted; pend_cnt=1.
  - Issue with rreg1=2: stall=1 and busy1=1, repeated every cycle.
  - Write wreg=2 (BYPASS=1): stall=0 and issue is accepted that cycle.
- WAW and simultaneous claim/clear:
  - r4 busy; issue ireg=4 with write=1, wreg=4 (BYPASS=1).
  - Required: the issue is accepted, r4 stays busy and pend_cnt is unchanged.
  - Issue ireg=4 without a write: stall=1.
- ZERO_REG=1:
  - Write r0=16'hFFFF; the read returns 0.
  - Issue ireg=0 is accepted; busy[0] stays 0 and pend_cnt stays 0.
  - rreg1=0 never stalls.
- Reset mid-operation (WIDTH=32, ADDR_W=4):
  - Claim 3 registers (pend_cnt=3) and write data, then assert rst asynchronously between edges.
  - Required: immediately busy=0, pend_cnt=0 and all reads 0. After release an issue with those sources is accepted with no stall.

Source files
------------

// File: rtl/register_file_sb.sv
// Parametrised register file with per-register busy scoreboard for decode-stage
// RAW/WAW hazard detection, optional hardwired zero register and write bypass.

module register_file_sb_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             claim,
  input  logic             clr,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] q,
  output logic             busy
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      busy <= 1'b0;
    end else begin
      if (we) q <= wd;
      // A new producer claiming the register outranks the retiring writer
      if (claim)    busy <= 1'b1;
      else if (clr) busy <= 1'b0;
    end
  end
endmodule

module register_file_sb #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic [ADDR_W-1:0] wreg,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] rreg1,
  input  logic [ADDR_W-1:0] rreg2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic              issue,
  input  logic [ADDR_W-1:0] ireg,
  output logic              stall,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   pend_cnt
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            busy;
  logic [DEPTH-1:0]            we_v, claim_v, clr_v;
  logic                        wbusy, acc, set_eff, clr_eff;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic fwd_hit(input logic w, input logic [ADDR_W-1:0] wa,
                                   input logic [ADDR_W-1:0] a);
    return (BYPASS != 0) && w && (wa == a);
  endfunction

  always_comb begin
    rd1 = regs[rreg1];
    rd2 = regs[rreg2];
    if (is_zero(rreg1))                   rd1 = '0;
    else if (fwd_hit(write, wreg, rreg1)) rd1 = wd;
    if (is_zero(rreg2))                   rd2 = '0;
    else if (fwd_hit(write, wreg, rreg2)) rd2 = wd;
  end

  // Effective busy: a same-cycle forwarded write already satisfies the hazard
  always_comb begin
    busy1 = busy[rreg1] & ~is_zero(rreg1) & ~fwd_hit(write, wreg, rreg1);
    busy2 = busy[rreg2] & ~is_zero(rreg2) & ~fwd_hit(write, wreg, rreg2);
    wbusy = busy[ireg]  & ~is_zero(ireg)  & ~fwd_hit(write, wreg, ireg);
    stall = issue & (busy1 | busy2 | wbusy);
    acc   = issue & ~stall;
  end

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_reg
      always_comb begin
        we_v[i]    = write & (wreg == ADDR_W'(i)) & ~is_zero(ADDR_W'(i));
        claim_v[i] = acc & (ireg == ADDR_W'(i)) & ~is_zero(ADDR_W'(i));
        clr_v[i]   = write & (wreg == ADDR_W'(i));
      end
      register_file_sb_cell #(.WIDTH(WIDTH)) u_cell (
        .clk   (clk),
        .rst   (rst),
        .we    (we_v[i]),
        .claim (claim_v[i]),
        .clr   (clr_v[i]),
        .wd    (wd),
        .q     (regs[i]),
        .busy  (busy[i])
      );
    end
  endgenerate

  // Count tracks popcount(busy) with only bit transitions contributing
  always_comb begin
    set_eff = acc & ~is_zero(ireg) & ~busy[ireg];
    clr_eff = write & busy[wreg] & ~(acc & (ireg == wreg));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_cnt <= '0;
    else begin
      case ({set_eff, clr_eff})
        2'b10:   pend_cnt <= pend_cnt + 1'b1;
        2'b01:   pend_cnt <= pend_cnt - 1'b1;
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench: four configurations share one randomized/directed stimulus
// stream; a reference model predicts outputs that a negedge monitor compares.
`timescale 1ns/1ps
module tb_register_file_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write = 1'b0, issue = 1'b0;
  logic [3:0]  wreg = '0, rreg1 = '0, rreg2 = '0, ireg = '0;
  logic [31:0] wd = '0;

  always #5 clk = ~clk;

  // cfg0: defaults, cfg1: BYPASS=0, cfg2: ZERO_REG=1, cfg3: WIDTH=32 ADDR_W=4
  int aw [4] = '{3, 3, 3, 4};
  int dw [4] = '{16, 16, 16, 32};
  int zr [4] = '{0, 0, 1, 0};
  int bp [4] = '{1, 0, 1, 1};

  logic [15:0] rd1_0, rd2_0, rd1_1, rd2_1, rd1_2, rd2_2;
  logic [31:0] rd1_3, rd2_3;
  logic        st_0, st_1, st_2, st_3;
  logic        b1_0, b2_0, b1_1, b2_1, b1_2, b2_2, b1_3, b2_3;
  logic [3:0]  pc_0, pc_1, pc_2;
  logic [4:0]  pc_3;

  register_file_sb u0 (.clk(clk), .rst(rst), .write(write), .wreg(wreg[2:0]), .wd(wd[15:0]),
    .rreg1(rreg1[2:0]), .rreg2(rreg2[2:0]), .rd1(rd1_0), .rd2(rd2_0), .issue(issue),
    .ireg(ireg[2:0]), .stall(st_0), .busy1(b1_0), .busy2(b2_0), .pend_cnt(pc_0));
  register_file_sb #(.BYPASS(0)) u1 (.clk(clk), .rst(rst), .write(write), .wreg(wreg[2:0]),
    .wd(wd[15:0]), .rreg1(rreg1[2:0]), .rreg2(rreg2[2:0]), .rd1(rd1_1), .rd2(rd2_1),
    .issue(issue), .ireg(ireg[2:0]), .stall(st_1), .busy1(b1_1), .busy2(b2_1), .pend_cnt(pc_1));
  register_file_sb #(.ZERO_REG(1)) u2 (.clk(clk), .rst(rst), .write(write), .wreg(wreg[2:0]),
    .wd(wd[15:0]), .rreg1(rreg1[2:0]), .rreg2(rreg2[2:0]), .rd1(rd1_2), .rd2(rd2_2),
    .issue(issue), .ireg(ireg[2:0]), .stall(st_2), .busy1(b1_2), .busy2(b2_2), .pend_cnt(pc_2));
  register_file_sb #(.WIDTH(32), .ADDR_W(4)) u3 (.clk(clk), .rst(rst), .write(write),
    .wreg(wreg), .wd(wd), .rreg1(rreg1), .rreg2(rreg2), .rd1(rd1_3), .rd2(rd2_3),
    .issue(issue), .ireg(ireg), .stall(st_3), .busy1(b1_3), .busy2(b2_3), .pend_cnt(pc_3));

  logic [31:0] a_rd1 [4], a_rd2 [4];
  logic [7:0]  a_pc [4];
  logic        a_st [4], a_b1 [4], a_b2 [4];
  assign a_rd1[0] = {16'h0, rd1_0}; assign a_rd2[0] = {16'h0, rd2_0};
  assign a_rd1[1] = {16'h0, rd1_1}; assign a_rd2[1] = {16'h0, rd2_1};
  assign a_rd1[2] = {16'h0, rd1_2}; assign a_rd2[2] = {16'h0, rd2_2};
  assign a_rd1[3] = rd1_3;          assign a_rd2[3] = rd2_3;
  assign a_pc[0] = {4'h0, pc_0}; assign a_pc[1] = {4'h0, pc_1};
  assign a_pc[2] = {4'h0, pc_2}; assign a_pc[3] = {3'h0, pc_3};
  assign a_st[0] = st_0; assign a_st[1] = st_1; assign a_st[2] = st_2; assign a_st[3] = st_3;
  assign a_b1[0] = b1_0; assign a_b1[1] = b1_1; assign a_b1[2] = b1_2; assign a_b1[3] = b1_3;
  assign a_b2[0] = b2_0; assign a_b2[1] = b2_1; assign a_b2[2] = b2_2; assign a_b2[3] = b2_3;

  typedef struct {
    logic [31:0] rd1, rd2;
    logic        b1, b2, st;
    logic [7:0]  pc;
  } exp_t;

  exp_t        sbq [4][$];
  logic [31:0] mregs [4][16];
  bit          mbusy [4][16];
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d @%0t: got %0h want %0h", nm, c, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 16; r++) begin
        mregs[c][r] = '0;
        mbusy[c][r] = 1'b0;
      end
  endtask

  // Reference: reads and busy with zero-register and forwarding rules applied
  function automatic logic [31:0] m_read(int c, int a, int wa, logic [31:0] d);
    if (zr[c] != 0 && a == 0) return '0;
    if (bp[c] != 0 && write && wa == a) return d;
    return mregs[c][a];
  endfunction

  function automatic bit m_busy(int c, int a, int wa);
    if (zr[c] != 0 && a == 0) return 1'b0;
    if (bp[c] != 0 && write && wa == a) return 1'b0;
    return mbusy[c][a];
  endfunction

  task automatic cyc(input bit r, input bit w, input int wr, input logic [31:0] d,
                     input int a1, input int a2, input bit is, input int ir);
    @(posedge clk); #1;
    rst = r; write = w; wreg = 4'(wr); wd = d;
    rreg1 = 4'(a1); rreg2 = 4'(a2); issue = is; ireg = 4'(ir);
    if (!r) model_clear();
    for (int c = 0; c < 4; c++) begin
      int m = (1 << aw[c]) - 1;
      int wa = wr & m, ra1 = a1 & m, ra2 = a2 & m, ia = ir & m;
      logic [31:0] dd = (dw[c] == 32) ? d : {16'h0, d[15:0]};
      exp_t e;
      int cnt = 0;
      bit acc;
      for (int k = 0; k < 16; k++) cnt += int'(mbusy[c][k]);
      e.rd1 = m_read(c, ra1, wa, dd);
      e.rd2 = m_read(c, ra2, wa, dd);
      e.b1  = m_busy(c, ra1, wa);
      e.b2  = m_busy(c, ra2, wa);
      e.st  = is & (e.b1 | e.b2 | m_busy(c, ia, wa));
      e.pc  = 8'(cnt);
      sbq[c].push_back(e);
      acc = is & ~e.st;
      if (r) begin
        if (w) begin
          if (!(zr[c] != 0 && wa == 0)) mregs[c][wa] = dd;
          mbusy[c][wa] = 1'b0;
        end
        if (acc && !(zr[c] != 0 && ia == 0)) mbusy[c][ia] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (sbq[c].size() > 0) begin
        exp_t e;
        e = sbq[c].pop_front();
        chk("rd1", c, a_rd1[c], e.rd1);
        chk("rd2", c, a_rd2[c], e.rd2);
        chk("busy1", c, 32'(a_b1[c]), 32'(e.b1));
        chk("busy2", c, 32'(a_b2[c]), 32'(e.b2));
        chk("stall", c, 32'(a_st[c]), 32'(e.st));
        chk("pend_cnt", c, 32'(a_pc[c]), 32'(e.pc));
      end
    end
  end

  initial begin
    model_clear();
    #1 rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 3, 32'h5555, 3, 3, 1, 3);               // ignored while in reset
    cyc(1, 0, 0, 0, 3, 1, 0, 0);
    cyc(1, 1, 3, 32'hBEEF, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 3, 0, 0, 0);
    cyc(1, 1, 5, 32'h1234, 0, 5, 0, 0);               // bypass vs. old value
    cyc(1, 0, 0, 0, 5, 5, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 2);                      // claim r2
    repeat (3) cyc(1, 0, 0, 0, 2, 3, 1, 1);           // RAW stall repeats
    cyc(1, 1, 2, 32'hAAAA, 2, 3, 1, 1);               // writeback releases
    cyc(1, 0, 0, 0, 0, 0, 1, 4);                      // claim r4
    cyc(1, 1, 4, 32'h4444, 0, 0, 1, 4);               // simultaneous clear/claim
    cyc(1, 0, 0, 0, 0, 0, 1, 4);                      // WAW stall
    cyc(1, 1, 4, 32'h4545, 4, 0, 0, 0);
    cyc(1, 1, 1, 32'h1111, 0, 0, 0, 0);
    cyc(1, 1, 0, 32'hFFFF, 0, 0, 0, 0);               // zero register write
    cyc(1, 0, 0, 0, 0, 0, 1, 0);                      // zero register claim
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);                      // mid-op reset scenario
    cyc(1, 0, 0, 0, 0, 0, 1, 6);
    cyc(1, 0, 0, 0, 0, 0, 1, 7);
    cyc(1, 0, 0, 0, 0, 0, 1, 9);
    cyc(1, 1, 10, 32'hCAFEF00D, 6, 7, 0, 0);
    cyc(1, 0, 0, 0, 10, 9, 0, 0);
    cyc(0, 0, 0, 0, 6, 10, 0, 0);                     // async assert between edges
    cyc(0, 1, 6, 32'h77, 6, 7, 1, 9);
    cyc(1, 0, 0, 0, 6, 7, 1, 9);                      // accepted after release
    cyc(1, 0, 0, 0, 9, 10, 0, 0);
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 63) != 0), $urandom_range(0, 1), $urandom_range(0, 15), $urandom,
          $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
          $urandom_range(0, 15));
    end
    repeat (3) @(posedge clk);
    for (int c = 0; c < 4; c++) chk("sb_drained", c, 32'(sbq[c].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
